// File: rtl/dijkstra_axil_regbank_if.sv
// AXI4-Lite slave bus bundle for the Dijkstra engine register bank.
// The slave modport is used by dijkstra_axil_regbank; the master modport by
// whatever drives the bus (interconnect or testbench).
interface dijkstra_axil_regbank_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   awaddr;
   logic [2:0]          awprot;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ADDR_W-1:0]   araddr;
   logic [2:0]          arprot;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/dijkstra_axil_regbank.sv
// AXI4-Lite register bank for the Dijkstra path-search engine.
// Word map: 0 CTRL, 1 STATUS, 2..NUM_RW+1 config words (RW, byte-enabled),
// NUM_RW+2..NUM_RW+NUM_RO+1 status words (RO). Everything else is unmapped.
// Optional feature macro: DIJKSTRA_AXIL_IRQ_EN enables the IRQ_EN bit and the
// registered completion interrupt; without it irq is tied low.
module dijkstra_axil_regbank #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int NUM_RW             = 4,
   parameter int NUM_RO             = 4,
   parameter int C_S_AXI_ADDR_WIDTH = 8
) (
   input  logic                                     s00_axi_aclk,
   input  logic                                     s00_axi_aresetn,
   dijkstra_axil_regbank_if.slave                   s00_axi,
   output logic                                     eng_start,
   input  logic                                     eng_busy,
   input  logic                                     eng_done,
   output logic [32*NUM_RW-1:0]                     cfg_regs,
   input  logic [32*((NUM_RO > 0) ? NUM_RO : 1)-1:0] sts_regs,
   output logic                                     irq
);

   localparam int         IDX_W       = C_S_AXI_ADDR_WIDTH - 2;
   localparam int         IDX_STS     = NUM_RW + 2;
   localparam int         IDX_END     = NUM_RW + NUM_RO + 2;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // write channel state
   logic             r_aw_held;
   logic             r_w_held;
   logic [IDX_W-1:0] r_aw_idx;
   logic [31:0]      r_wdata;
   logic [3:0]       r_wstrb;
   logic             r_bvalid;
   logic [1:0]       r_bresp;

   // read channel state
   logic             r_rvalid;
   logic [31:0]      r_rdata;
   logic [1:0]       r_rresp;

   // register contents
   logic [31:0]      r_cfg [NUM_RW];
   logic             r_done;
   logic             r_start_err;
   logic             r_eng_start;

   logic             w_aw_hs;
   logic             w_w_hs;
   logic             w_b_hs;
   logic             w_ar_hs;
   logic             w_commit;
   int               w_widx;
   int               w_ridx;
   logic             w_wr_ctrl;
   logic             w_wr_status;
   logic             w_start_req;
   logic             w_irq_en;
   logic [31:0]      w_rd_data;
   logic [1:0]       w_rd_resp;
   logic             w_unused;

   // Ready signals are gated by reset so they read 0 while reset is held.
   assign s00_axi.awready = s00_axi_aresetn & ~r_aw_held & ~r_bvalid;
   assign s00_axi.wready  = s00_axi_aresetn & ~r_w_held & ~r_bvalid;
   assign s00_axi.arready = s00_axi_aresetn & ~r_rvalid;
   assign s00_axi.bvalid  = r_bvalid;
   assign s00_axi.bresp   = r_bresp;
   assign s00_axi.rvalid  = r_rvalid;
   assign s00_axi.rdata   = r_rdata;
   assign s00_axi.rresp   = r_rresp;
   assign eng_start       = r_eng_start;

   assign w_aw_hs  = s00_axi.awvalid & s00_axi.awready;
   assign w_w_hs   = s00_axi.wvalid & s00_axi.wready;
   assign w_b_hs   = r_bvalid & s00_axi.bready;
   assign w_ar_hs  = s00_axi.arvalid & s00_axi.arready;
   // A write commits on the first edge both halves are held; bvalid blocks a repeat.
   assign w_commit = r_aw_held & r_w_held & ~r_bvalid;

   assign w_widx      = int'(r_aw_idx);
   assign w_ridx      = int'(s00_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2]);
   assign w_wr_ctrl   = w_commit & (w_widx == 0) & r_wstrb[0];
   assign w_wr_status = w_commit & (w_widx == 1) & r_wstrb[0];
   assign w_start_req = w_wr_ctrl & r_wdata[0];

   assign w_unused = ^{s00_axi.awprot, s00_axi.arprot,
                       s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

   // Capture AW and W independently, commit when both are held, retire on B handshake.
   always_ff @(posedge s00_axi_aclk) begin
      if (!s00_axi_aresetn) begin
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
      end else begin
         if (w_aw_hs) begin
            r_aw_held <= 1'b1;
            r_aw_idx  <= s00_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
         end
         if (w_w_hs) begin
            r_w_held <= 1'b1;
            r_wdata  <= s00_axi.wdata;
            r_wstrb  <= s00_axi.wstrb;
         end
         if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= (w_widx < IDX_STS) ? RESP_OKAY : RESP_SLVERR;
         end
         if (w_b_hs) begin
            r_bvalid  <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
         end
      end
   end

   // Config words: byte-enabled update on commit.
   always_ff @(posedge s00_axi_aclk) begin
      if (!s00_axi_aresetn) begin
         for (int k = 0; k < NUM_RW; k++) r_cfg[k] <= '0;
      end else if (w_commit) begin
         for (int k = 0; k < NUM_RW; k++) begin
            if (w_widx == k + 2) begin
               for (int b = 0; b < 4; b++) begin
                  if (r_wstrb[b]) r_cfg[k][8*b +: 8] <= r_wdata[8*b +: 8];
               end
            end
         end
      end
   end

   // Flatten config words onto the output bus.
   always_comb begin
      cfg_regs = '0;
      for (int k = 0; k < NUM_RW; k++) cfg_regs[32*k +: 32] = r_cfg[k];
   end

   // Start pulse, sticky DONE / START_ERR; a set from the engine beats a clear.
   always_ff @(posedge s00_axi_aclk) begin
      if (!s00_axi_aresetn) begin
         r_eng_start <= 1'b0;
         r_done      <= 1'b0;
         r_start_err <= 1'b0;
      end else begin
         r_eng_start <= w_start_req & ~eng_busy;
         r_done      <= eng_done | (r_done & ~(w_wr_status & r_wdata[1]));
         r_start_err <= (w_start_req & eng_busy) |
                        (r_start_err & ~(w_wr_status & r_wdata[2]));
      end
   end

`ifdef DIJKSTRA_AXIL_IRQ_EN
   logic r_irq_en;
   logic r_irq;

   // Interrupt enable bit and registered level interrupt (one cycle behind DONE).
   always_ff @(posedge s00_axi_aclk) begin
      if (!s00_axi_aresetn) begin
         r_irq_en <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         if (w_wr_ctrl) r_irq_en <= r_wdata[1];
         r_irq <= r_irq_en & r_done;
      end
   end

   assign w_irq_en = r_irq_en;
   assign irq      = r_irq;
`else
   assign w_irq_en = 1'b0;
   assign irq      = 1'b0;
`endif

   // Read decode; unmapped words return zero with SLVERR.
   always_comb begin
      w_rd_data = '0;
      w_rd_resp = RESP_OKAY;
      if (w_ridx == 0) begin
         w_rd_data = {30'd0, w_irq_en, 1'b0};
      end else if (w_ridx == 1) begin
         w_rd_data = {29'd0, r_start_err, r_done, eng_busy};
      end else if (w_ridx < IDX_STS) begin
         for (int k = 0; k < NUM_RW; k++) begin
            if (w_ridx == k + 2) w_rd_data = r_cfg[k];
         end
      end else if (w_ridx < IDX_END) begin
         for (int k = 0; k < NUM_RO; k++) begin
            if (w_ridx == IDX_STS + k) w_rd_data = sts_regs[32*k +: 32];
         end
      end else begin
         w_rd_resp = RESP_SLVERR;
      end
   end

   // Register read data on AR handshake and hold it until rready.
   always_ff @(posedge s00_axi_aclk) begin
      if (!s00_axi_aresetn) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_rresp  <= RESP_OKAY;
      end else if (w_ar_hs) begin
         r_rvalid <= 1'b1;
         r_rdata  <= w_rd_data;
         r_rresp  <= w_rd_resp;
      end else if (s00_axi.rready) begin
         r_rvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dijkstra_axil_regbank.sv
// Bench for dijkstra_axil_regbank: directed scenarios plus randomized
// register traffic checked against a word-level model of the register map.
module tb_dijkstra_axil_regbank;

   localparam int NRW = 4;
   localparam int NRO = 2;

   logic             clk = 1'b0;
   logic             aresetn;
   logic             eng_start;
   logic             eng_busy;
   logic             eng_done;
   logic [32*NRW-1:0] cfg_regs;
   logic [32*NRO-1:0] sts_regs;
   logic             irq;
   logic [31:0]      sts_val [NRO];

   dijkstra_axil_regbank_if #(.ADDR_W(8), .DATA_W(32)) s00_axi ();

   dijkstra_axil_regbank #(
      .C_S_AXI_DATA_WIDTH(32),
      .NUM_RW(NRW),
      .NUM_RO(NRO),
      .C_S_AXI_ADDR_WIDTH(8)
   ) dut (
      .s00_axi_aclk(clk),
      .s00_axi_aresetn(aresetn),
      .s00_axi(s00_axi),
      .eng_start(eng_start),
      .eng_busy(eng_busy),
      .eng_done(eng_done),
      .cfg_regs(cfg_regs),
      .sts_regs(sts_regs),
      .irq(irq)
   );

   always #5 clk = ~clk;

   assign sts_regs = {sts_val[1], sts_val[0]};

   int n_chk = 0;
   int n_err = 0;
   int start_cnt = 0;
   logic irq_at_b;

   // reference model state
   logic [31:0] m_cfg [NRW];
   logic        m_done;
   logic        m_err;
   logic        m_irq_en;
   int          m_start;

   // count eng_start high cycles, sampled away from the active edge
   always @(negedge clk) if (eng_start) start_cnt++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void mdl_reset();
      for (int k = 0; k < NRW; k++) m_cfg[k] = 32'd0;
      m_done   = 1'b0;
      m_err    = 1'b0;
      m_irq_en = 1'b0;
   endfunction

   function automatic void mdl_write(input logic [7:0] addr, input logic [31:0] data,
                                     input logic [3:0] strb, input logic busy,
                                     output logic [1:0] resp);
      int idx;
      idx  = int'(addr[7:2]);
      resp = 2'b00;
      if (idx == 0) begin
         if (strb[0]) begin
`ifdef DIJKSTRA_AXIL_IRQ_EN
            m_irq_en = data[1];
`endif
            if (data[0]) begin
               if (busy) m_err = 1'b1;
               else m_start++;
            end
         end
      end else if (idx == 1) begin
         if (strb[0]) begin
            if (data[1]) m_done = 1'b0;
            if (data[2]) m_err = 1'b0;
         end
      end else if (idx < 2 + NRW) begin
         for (int b = 0; b < 4; b++)
            if (strb[b]) m_cfg[idx-2][8*b +: 8] = data[8*b +: 8];
      end else begin
         resp = 2'b10;
      end
   endfunction

   function automatic void mdl_read(input logic [7:0] addr, output logic [31:0] d,
                                    output logic [1:0] r);
      int idx;
      idx = int'(addr[7:2]);
      d = 32'd0;
      r = 2'b00;
      if (idx == 0)                 d = {30'd0, m_irq_en, 1'b0};
      else if (idx == 1)            d = {29'd0, m_err, m_done, eng_busy};
      else if (idx < 2 + NRW)       d = m_cfg[idx-2];
      else if (idx < 2 + NRW + NRO) d = sts_val[idx-2-NRW];
      else                          r = 2'b10;
   endfunction

   task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input bit pulse_at_commit,
                            input logic [1:0] exp_resp, input string tag);
      bit aw_ok, w_ok, a_now, w_now;
      int cnt;
      @(negedge clk);
      s00_axi.awaddr  = addr;
      s00_axi.awvalid = 1'b1;
      s00_axi.wdata   = data;
      s00_axi.wstrb   = strb;
      s00_axi.wvalid  = 1'b1;
      aw_ok = 0; w_ok = 0; cnt = 0;
      while (!(aw_ok && w_ok) && cnt < 50) begin
         a_now = s00_axi.awvalid && s00_axi.awready;
         w_now = s00_axi.wvalid && s00_axi.wready;
         @(posedge clk);
         if (a_now) aw_ok = 1;
         if (w_now) w_ok = 1;
         @(negedge clk);
         if (aw_ok) s00_axi.awvalid = 1'b0;
         if (w_ok)  s00_axi.wvalid  = 1'b0;
         cnt++;
      end
      if (!(aw_ok && w_ok)) chk({tag, "_hs_timeout"}, 64'd0, 64'd1);
      s00_axi.awvalid = 1'b0;
      s00_axi.wvalid  = 1'b0;
      if (pulse_at_commit) eng_done = 1'b1;
      cnt = 0;
      while (!s00_axi.bvalid && cnt < 50) begin
         @(negedge clk);
         eng_done = 1'b0;
         cnt++;
      end
      eng_done = 1'b0;
      chk({tag, "_bvalid"}, s00_axi.bvalid, 1);
      chk({tag, "_bresp"}, s00_axi.bresp, exp_resp);
      irq_at_b = irq;
      s00_axi.bready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s00_axi.bready = 1'b0;
   endtask

   task automatic axi_read(input logic [7:0] addr, input int hold,
                           input logic [31:0] exp_d, input logic [1:0] exp_r,
                           input string tag);
      bit ar_now;
      int cnt;
      @(negedge clk);
      s00_axi.araddr  = addr;
      s00_axi.arvalid = 1'b1;
      cnt = 0;
      ar_now = 0;
      while (!ar_now && cnt < 50) begin
         ar_now = s00_axi.arready;
         @(posedge clk);
         @(negedge clk);
         cnt++;
      end
      s00_axi.arvalid = 1'b0;
      if (!ar_now) chk({tag, "_ar_timeout"}, 64'd0, 64'd1);
      cnt = 0;
      while (!s00_axi.rvalid && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      chk({tag, "_rvalid"}, s00_axi.rvalid, 1);
      chk({tag, "_rdata"}, s00_axi.rdata, exp_d);
      chk({tag, "_rresp"}, s00_axi.rresp, exp_r);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk({tag, "_hold_rvalid"}, s00_axi.rvalid, 1);
         chk({tag, "_hold_rdata"}, s00_axi.rdata, exp_d);
      end
      s00_axi.rready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s00_axi.rready = 1'b0;
   endtask

   task automatic mwrite(input logic [7:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input string tag);
      logic [1:0] er;
      mdl_write(addr, data, strb, eng_busy, er);
      axi_write(addr, data, strb, 1'b0, er, tag);
   endtask

   task automatic mread(input logic [7:0] addr, input int hold, input string tag);
      logic [31:0] ed;
      logic [1:0]  er;
      mdl_read(addr, ed, er);
      axi_read(addr, hold, ed, er, tag);
   endtask

   task automatic pulse_done();
      @(negedge clk);
      eng_done = 1'b1;
      @(negedge clk);
      eng_done = 1'b0;
      m_done = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      logic [1:0]  er;
      logic [5:0]  ridx;
      logic [7:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          sc;

      aresetn = 1'b0;
      eng_busy = 1'b0;
      eng_done = 1'b0;
      sts_val[0] = 32'hCAFE0001;
      sts_val[1] = 32'h5A5A5A5A;
      s00_axi.awaddr = '0; s00_axi.awprot = '0; s00_axi.awvalid = 1'b0;
      s00_axi.wdata = '0;  s00_axi.wstrb = '0;  s00_axi.wvalid = 1'b0;
      s00_axi.bready = 1'b0;
      s00_axi.araddr = '0; s00_axi.arprot = '0; s00_axi.arvalid = 1'b0;
      s00_axi.rready = 1'b0;
      mdl_reset();
      m_start = 0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_awready", s00_axi.awready, 0);
      chk("rst_wready", s00_axi.wready, 0);
      chk("rst_arready", s00_axi.arready, 0);
      chk("rst_bvalid", s00_axi.bvalid, 0);
      chk("rst_rvalid", s00_axi.rvalid, 0);
      chk("rst_eng_start", eng_start, 0);
      chk("rst_irq", irq, 0);
      chk("rst_cfg_regs", cfg_regs[63:0], 64'd0);
      aresetn = 1'b1;
      @(negedge clk);
      chk("post_rst_awready", s00_axi.awready, 1);
      chk("post_rst_arready", s00_axi.arready, 1);

      // config words 1..4 and read back
      for (int k = 0; k < NRW; k++) mwrite(8'(8 + 4*k), 32'(k + 1), 4'hF, "cfg_wr");
      for (int k = 0; k < NRW; k++) mread(8'(8 + 4*k), 0, "cfg_rd");
      for (int k = 0; k < NRW; k++) chk("cfg_regs_seq", cfg_regs[32*k +: 32], 64'(k + 1));

      // W three cycles before AW, partial strobes
      mwrite(8'h08, 32'h11111111, 4'hF, "pre_strb");
      @(negedge clk);
      s00_axi.wdata  = 32'hAABBCCDD;
      s00_axi.wstrb  = 4'b0101;
      s00_axi.wvalid = 1'b1;
      chk("wfirst_wready", s00_axi.wready, 1);
      @(posedge clk);
      @(negedge clk);
      s00_axi.wvalid = 1'b0;
      chk("wfirst_wready_held", s00_axi.wready, 0);
      repeat (2) begin
         @(negedge clk);
         chk("wfirst_no_b", s00_axi.bvalid, 0);
      end
      s00_axi.awaddr  = 8'h08;
      s00_axi.awvalid = 1'b1;
      @(negedge clk);
      s00_axi.awvalid = 1'b0;
      chk("wfirst_b_t3", s00_axi.bvalid, 0);
      @(negedge clk);
      chk("wfirst_b_t4", s00_axi.bvalid, 1);
      chk("wfirst_bresp", s00_axi.bresp, 2'b00);
      s00_axi.bready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s00_axi.bready = 1'b0;
      mdl_write(8'h08, 32'hAABBCCDD, 4'b0101, eng_busy, er);
      chk("wfirst_model", m_cfg[0], 64'h11BB11DD);
      mread(8'h08, 0, "wfirst_rd");

      // START idle and busy
      sc = start_cnt;
      mwrite(8'h00, 32'h1, 4'h1, "start_idle");
      @(negedge clk);
      chk("start_pulse_cnt", 64'(start_cnt - sc), 64'd1);
      eng_busy = 1'b1;
      sc = start_cnt;
      mwrite(8'h00, 32'h1, 4'h1, "start_busy");
      @(negedge clk);
      chk("start_busy_no_pulse", 64'(start_cnt - sc), 64'd0);
      chk("start_busy_model", {29'd0, m_err, m_done, eng_busy}, 64'h5);
      mread(8'h04, 0, "status_err");
      eng_busy = 1'b0;
      mwrite(8'h04, 32'h4, 4'h1, "err_clr");
      mread(8'h04, 0, "status_err_clr");

      // DONE set beats a same-cycle clear
      pulse_done();
      mread(8'h04, 0, "status_done");
      mdl_write(8'h04, 32'h2, 4'h1, eng_busy, er);
      m_done = 1'b1;
      axi_write(8'h04, 32'h2, 4'h1, 1'b1, er, "done_race");
      mread(8'h04, 0, "done_race_rd");
      mwrite(8'h04, 32'h2, 4'h1, "done_clr");
      mread(8'h04, 0, "done_clr_rd");

      // RO / unmapped accesses
      mwrite(8'h18, 32'hDEADBEEF, 4'hF, "ro_wr");
      mread(8'h18, 0, "ro_rd");
      mread(8'hFC, 5, "unmapped_rd");

`ifdef DIJKSTRA_AXIL_IRQ_EN
      mwrite(8'h00, 32'h2, 4'h1, "irq_en_wr");
      mread(8'h00, 0, "irq_en_rd");
      @(negedge clk);
      eng_done = 1'b1;
      @(negedge clk);
      eng_done = 1'b0;
      m_done = 1'b1;
      chk("irq_lag", irq, 0);
      @(negedge clk);
      chk("irq_rise", irq, 1);
      mwrite(8'h04, 32'h2, 4'h1, "irq_done_clr");
      chk("irq_at_clear", irq_at_b, 1);
      chk("irq_fall", irq, 0);
`else
      mwrite(8'h00, 32'h2, 4'h1, "irq_en_wr");
      mread(8'h00, 0, "irq_en_rd");
      pulse_done();
      chk("irq_tied", irq, 0);
`endif

      // randomized traffic
      for (int it = 0; it < 120; it++) begin
         @(negedge clk);
         eng_busy = ($urandom_range(0, 3) == 0);
         sts_val[$urandom_range(0, NRO-1)] = $urandom;
         if ($urandom_range(0, 4) == 0) pulse_done();
         sc = $urandom_range(0, 11);
         if (sc < 10)       ridx = 6'(sc);
         else if (sc == 10) ridx = 6'd63;
         else               ridx = 6'($urandom_range(8, 62));
         addr = {ridx, 2'($urandom_range(0, 3))};
         data = $urandom;
         strb = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1) begin
            mwrite(addr, data, strb, "rnd_wr");
            @(negedge clk);
            chk("rnd_start_cnt", 64'(start_cnt), 64'(m_start));
         end
         mread(addr, 0, "rnd_rd");
         for (int k = 0; k < NRW; k++) chk("rnd_cfg_regs", cfg_regs[32*k +: 32], m_cfg[k]);
         chk("rnd_irq", irq, m_irq_en & m_done);
      end
      eng_busy = 1'b0;

      // reset with AW captured and no W
      @(negedge clk);
      s00_axi.awaddr  = 8'h0C;
      s00_axi.awvalid = 1'b1;
      chk("midrst_awready", s00_axi.awready, 1);
      @(posedge clk);
      @(negedge clk);
      s00_axi.awvalid = 1'b0;
      aresetn = 1'b0;
      @(negedge clk);
      chk("midrst_in_rst_awready", s00_axi.awready, 0);
      chk("midrst_in_rst_irq", irq, 0);
      aresetn = 1'b1;
      mdl_reset();
      @(negedge clk);
      chk("midrst_after_awready", s00_axi.awready, 1);
      repeat (5) begin
         @(negedge clk);
         chk("midrst_no_bvalid", s00_axi.bvalid, 0);
      end
      for (int k = 0; k < NRW; k++) chk("midrst_cfg_regs", cfg_regs[32*k +: 32], 64'd0);
      mread(8'h00, 0, "midrst_ctrl");
      mread(8'h04, 0, "midrst_status");
      mread(8'h0C, 0, "midrst_cfg1");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
